// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one combinational ALU between NUM_REQ requesters.
// A round-robin pick is made in IDLE, the operands are registered into the ALU
// and the ALU outputs are captured in EXEC. The tagged response is then held in
// RESP until the consumer takes it.
// Optional feature macro: ALU_ARB_STATS_EN adds per-requester 16-bit
// saturating grant counters on output grant_cnt.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*5-1:0]   req_opcode,
  input  logic [NUM_REQ-1:0]     req_cin,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [4:0]             alu_opcode,
  output logic                   alu_cin,
  input  logic [31:0]            alu_result,
  input  logic [3:0]             alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [31:0]            rsp_result,
  output logic [3:0]             rsp_flags,
  output logic                   busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  grant_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [31:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]     alu_opcode_q, alu_opcode_d;
  logic           alu_cin_q, alu_cin_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_result_q, rsp_result_d;
  logic [3:0]     rsp_flags_q, rsp_flags_d;

  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic [31:0]    sel_a, sel_b;
  logic [4:0]     sel_opcode;
  logic           sel_cin;
  logic           accept;

  // Round-robin search starting one past the last grant, wrapping at NUM_REQ-1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    found  = 1'b0;
    winner = '0;
    cand   = last_grant_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + IDW'(1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (cand == IDW'(i)) && req_valid[i]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  // Payload mux for the winner and the one-hot ready, offered only in IDLE.
  always_comb begin
    sel_a      = '0;
    sel_b      = '0;
    sel_opcode = '0;
    sel_cin    = 1'b0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_a      = req_a[32*i +: 32];
        sel_b      = req_b[32*i +: 32];
        sel_opcode = req_opcode[5*i +: 5];
        sel_cin    = req_cin[i];
      end
      req_ready[i] = (state_q == S_IDLE) && found && (winner == IDW'(i));
    end
  end

  assign accept = (state_q == S_IDLE) && found;

  // Next-state and datapath-register update for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    alu_cin_d    = alu_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          alu_a_d      = sel_a;
          alu_b_d      = sel_b;
          alu_opcode_d = sel_opcode;
          alu_cin_d    = sel_cin;
          rsp_id_d     = winner;
          last_grant_d = winner;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        rsp_valid_d  = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous, so it lives inside the clocked branch and
    // the sensitivity list holds only the clock.
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      alu_cin_q    <= alu_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_cin    = alu_cin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != S_IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt_q;

  // One saturating accept counter per requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && (winner == IDW'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with two requesters and a stub logic-op ALU.
module tb_alu_rr_arbiter;

  localparam int NUM_REQ = 2;
  localparam int IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a, req_b;
  logic [NUM_REQ*5-1:0]  req_opcode;
  logic [NUM_REQ-1:0]    req_cin;
  logic [31:0]           alu_a, alu_b;
  logic [4:0]            alu_opcode;
  logic                  alu_cin;
  logic [31:0]           alu_result;
  logic [3:0]            alu_flags;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_result;
  logic [3:0]            rsp_flags;
  logic                  busy;
`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stub ALU covering the logic opcodes used here; flags {V,C,N,Z}.
  logic [31:0] m_res;
  always_comb begin
    case (alu_opcode)
      5'b00100: m_res = alu_a & alu_b;
      5'b00101: m_res = alu_a | alu_b;
      5'b00110: m_res = alu_a ^ alu_b;
      5'b00111: m_res = ~alu_a;
      default:  m_res = alu_a + alu_b;
    endcase
    alu_result = m_res;
    alu_flags  = {2'b00, m_res[31], (m_res == 32'd0)};
  end

  task automatic drive_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit idx, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_cycle();
    drive_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '0; req_a = '0; req_b = '0; req_opcode = '0; req_cin = '0;
    rsp_ready = 1'b1;
    do_reset();
    @(negedge clk);
    tests_run++;
    if ({req_ready, rsp_valid, busy} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready/valid/busy=%b required 0000", {req_ready, rsp_valid, busy});
    end
    tests_run++;
    if ({rsp_id, rsp_result, rsp_flags} !== '0) begin
      tests_failed++;
      $display("FAIL reset_rsp: id=%h result=%h flags=%h required all 0", rsp_id, rsp_result, rsp_flags);
    end
    tests_run++;
    if ({alu_a, alu_b, alu_opcode, alu_cin} !== '0) begin
      tests_failed++;
      $display("FAIL reset_alu: a=%h b=%h op=%h cin=%b required all 0", alu_a, alu_b, alu_opcode, alu_cin);
    end
  endtask

  task automatic test_single_and();
    drive_cycle();
    req_a[31:0] = 32'hFFFF0000; req_b[31:0] = 32'h0F0F0F0F; req_opcode[4:0] = 5'b00100;
    req_valid = 2'b01;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("FAIL and_accept: req_ready=%b required 01", req_ready);
    end
    drive_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    tests_run++;
    if ({busy, rsp_valid, req_ready, alu_a, alu_b, alu_opcode} !== {1'b1, 1'b0, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 5'b00100}) begin
      tests_failed++;
      $display("FAIL and_exec: busy=%b valid=%b ready=%b a=%h b=%h op=%b required 1 0 00 ffff0000 0f0f0f0f 00100",
               busy, rsp_valid, req_ready, alu_a, alu_b, alu_opcode);
    end
    @(negedge clk);
    tests_run++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 2'd0, 32'h0F0F0000, 4'b0000}) begin
      tests_failed++;
      $display("FAIL and_rsp: valid=%b id=%0d result=%h flags=%b required 1 0 0f0f0000 0000",
               rsp_valid, rsp_id, rsp_result, rsp_flags);
    end
    @(negedge clk);
    tests_run++;
    if ({rsp_valid, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL and_done: valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_contention();
    bit ok;
    req_a = {32'hAAAAAAAA, 32'hF0F00000};
    req_b = {32'hFFFFFFFF, 32'h00000F0F};
    req_opcode = {5'b00110, 5'b00101};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    do_reset();
    @(negedge clk);
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("FAIL cont_first_grant: req_ready=%b required 01", req_ready);
    end
    drive_cycle();
    req_valid = 2'b10;
    wait_rsp(ok);
    tests_run++;
    if (!ok || {rsp_id, rsp_result, rsp_flags} !== {2'd0, 32'hF0F00F0F, 4'b0010}) begin
      tests_failed++;
      $display("FAIL cont_rsp0: seen=%b id=%0d result=%h flags=%b required 1 0 f0f00f0f 0010",
               ok, rsp_id, rsp_result, rsp_flags);
    end
    @(negedge clk);
    tests_run++;
    if (req_ready !== 2'b10) begin
      tests_failed++;
      $display("FAIL cont_second_grant: req_ready=%b required 10", req_ready);
    end
    drive_cycle();
    req_valid = 2'b00;
    wait_rsp(ok);
    tests_run++;
    if (!ok || {rsp_id, rsp_result, rsp_flags} !== {2'd1, 32'h55555555, 4'b0000}) begin
      tests_failed++;
      $display("FAIL cont_rsp1: seen=%b id=%0d result=%h flags=%b required 1 1 55555555 0000",
               ok, rsp_id, rsp_result, rsp_flags);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit hold_ok;
    drive_cycle();
    rsp_ready = 1'b0;
    req_a[63:32] = 32'hFFFFFFFF; req_b[63:32] = 32'h0; req_opcode[9:5] = 5'b00111;
    req_valid = 2'b10;
    wait_ready(1'b1, ok);
    drive_cycle();
    // Requester 0 now requests too; it must not be accepted during RESP.
    req_a[31:0] = 32'h12345678; req_b[31:0] = 32'hFFFFFFFF; req_opcode[4:0] = 5'b00100;
    req_valid = 2'b01;
    wait_rsp(ok);
    hold_ok = ok;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready} !== {1'b1, 2'd1, 32'h0, 4'b0001, 2'b00})
        hold_ok = 1'b0;
    end
    tests_run++;
    if (!hold_ok) begin
      tests_failed++;
      $display("FAIL bp_hold: valid=%b id=%0d result=%h flags=%b ready=%b required 1 1 00000000 0001 00",
               rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready);
    end
    drive_cycle();
    rsp_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({rsp_valid, busy} !== 2'b11) begin
      tests_failed++;
      $display("FAIL bp_release_cycle: valid=%b busy=%b required 1 1", rsp_valid, busy);
    end
    @(negedge clk);
    tests_run++;
    if ({rsp_valid, req_ready} !== {1'b0, 2'b01}) begin
      tests_failed++;
      $display("FAIL bp_complete: valid=%b ready=%b required 0 01", rsp_valid, req_ready);
    end
    drive_cycle();
    req_valid = 2'b00;
    wait_rsp(ok);
    tests_run++;
    if (!ok || {rsp_id, rsp_result} !== {2'd0, 32'h12345678}) begin
      tests_failed++;
      $display("FAIL bp_follow: seen=%b id=%0d result=%h required 1 0 12345678", ok, rsp_id, rsp_result);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit quiet;
    drive_cycle();
    // Accept from requester 0 so that, without reset, requester 1 would win next.
    req_valid = 2'b01;
    wait_ready(1'b0, ok);
    drive_cycle();
    req_valid = 2'b00;
    rst = 1'b1;
    drive_cycle();
    rst = 1'b0;
    quiet = ok;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    tests_run++;
    if (!quiet) begin
      tests_failed++;
      $display("FAIL midrst_no_rsp: valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
    drive_cycle();
    req_valid = 2'b11;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("FAIL midrst_priority: req_ready=%b required 01", req_ready);
    end
    drive_cycle();
    req_valid = 2'b00;
    wait_rsp(ok);
  endtask

  task automatic test_fairness();
    bit ok;
    bit [1:0] exp_ready;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    do_reset();
    req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin
          ok = 1'b1;
          break;
        end
      end
      tests_run++;
      if (!ok || req_ready !== exp_ready) begin
        tests_failed++;
        $display("FAIL fair_grant%0d: seen=%b req_ready=%b required %b", k, ok, req_ready, exp_ready);
      end
      drive_cycle();
    end
    req_valid = 2'b00;
`ifdef ALU_ARB_STATS_EN
    @(negedge clk);
    tests_run++;
    if (grant_cnt !== {16'd6, 16'd6}) begin
      tests_failed++;
      $display("FAIL fair_stats: grant_cnt=%h required 00060006", grant_cnt);
    end
`endif
    wait_rsp(ok);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_and();
    test_contention();
    test_backpressure();
    test_mid_reset();
    test_fairness();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
